// File: rtl/gbsha_ttfir_pkg.sv
// ============================================================================
// Module   : gbsha_ttfir_pkg
// Brief    : Shared state encoding, width derivation and round/saturate helper
//            for the streaming FIR.
// Revision : 1.0
// ============================================================================
`default_nettype none

package gbsha_ttfir_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    function automatic int prod_width(input int bw_in);
        return 2 * bw_in;
    endfunction

    function automatic int sum_width(input int bw_in, input int n_taps);
        return prod_width(bw_in) + $clog2(n_taps);
    endfunction

    function automatic int beat_count(input int bw_sum, input int bw_out);
        return (bw_sum + bw_out - 1) / bw_out;
    endfunction

    // Round half up by adding half an LSB before the arithmetic shift, then clamp.
    function automatic longint round_sat(input longint sum, input int shift, input int bw_out);
        longint r;
        longint hi;
        longint lo;
        r  = (shift > 0) ? ((sum + (longint'(1) <<< (shift - 1))) >>> shift) : sum;
        hi = (longint'(1) <<< (bw_out - 1)) - 1;
        lo = -(longint'(1) <<< (bw_out - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gbsha_ttfir_mac.sv
// ============================================================================
// Module   : gbsha_ttfir_mac
// Brief    : Combinational N-tap multiply/accumulate, full precision.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gbsha_ttfir_mac
    import gbsha_ttfir_pkg::*;
#(
    parameter int N_TAPS = 4,
    parameter int BW_IN  = 6,
    parameter int BW_SUM = sum_width(BW_IN, N_TAPS)
) (
    input  logic signed [BW_IN-1:0]  h_i   [N_TAPS],
    input  logic signed [BW_IN-1:0]  x_i   [N_TAPS],
    output logic signed [BW_SUM-1:0] sum_o
);

    localparam int BW_PROD = prod_width(BW_IN);

    logic signed [BW_PROD-1:0] w_prod [N_TAPS];

    for (genvar k = 0; k < N_TAPS; k++) begin : g_prod
        assign w_prod[k] = BW_PROD'(h_i[k]) * BW_PROD'(x_i[k]);
    end

    always_comb begin
        sum_o = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            sum_o = sum_o + BW_SUM'(w_prod[k]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/gbsha_ttfir_stream.sv
// ============================================================================
// Module   : gbsha_ttfir_stream
// Brief    : Streaming N-tap FIR with valid/ready input, coefficient reload and
//            multi-beat output. Build option FIR_SAT_EN: one rounded beat.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gbsha_ttfir_stream
    import gbsha_ttfir_pkg::*;
#(
    parameter int N_TAPS = 4,
    parameter int BW_IN  = 6,
    parameter int BW_OUT = 8,
    parameter int SHIFT  = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BW_IN-1:0]  in_data,
    input  logic              coef_reload,
    output logic              loaded,
    output logic              y_valid,
    output logic              y_last,
    output logic [BW_OUT-1:0] y_data
);

    localparam int BW_SUM = sum_width(BW_IN, N_TAPS);
`ifdef FIR_SAT_EN
    localparam int BEATS  = 1;
`else
    localparam int BEATS  = beat_count(BW_SUM, BW_OUT);
`endif
    localparam int BW_SR  = BEATS * BW_OUT;
    localparam int CW     = $clog2(N_TAPS);
    localparam int BCW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_e                   state_q;
    logic [CW-1:0]            coef_cnt_q;
    logic [BCW-1:0]           beat_cnt_q;
    logic signed [BW_IN-1:0]  h_q [N_TAPS];
    logic signed [BW_IN-1:0]  x_q [N_TAPS];
    logic                     in_ready_q;
    logic                     loaded_q;
    logic                     y_valid_q;
    logic                     y_last_q;
    logic [BW_OUT-1:0]        y_data_q;
    logic [BW_SR-1:0]         shreg_q;

    logic signed [BW_IN-1:0]  w_x_next [N_TAPS];
    logic signed [BW_SUM-1:0] w_sum;
    logic [BW_SR-1:0]         w_word;
    logic                     w_xfer;

    assign w_xfer = in_valid & in_ready_q;

    // The MAC sees the delay line as it will be after this sample shifts in.
    assign w_x_next[0] = signed'(in_data);
    for (genvar k = 1; k < N_TAPS; k++) begin : g_xnext
        assign w_x_next[k] = x_q[k-1];
    end

    gbsha_ttfir_mac #(
        .N_TAPS (N_TAPS),
        .BW_IN  (BW_IN),
        .BW_SUM (BW_SUM)
    ) u_mac (
        .h_i   (h_q),
        .x_i   (w_x_next),
        .sum_o (w_sum)
    );

`ifdef FIR_SAT_EN
    assign w_word = BW_SR'(round_sat(longint'(w_sum), SHIFT, BW_OUT));
`else
    assign w_word = BW_SR'(w_sum);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_LOAD;
            coef_cnt_q <= '0;
            beat_cnt_q <= '0;
            in_ready_q <= 1'b1;
            loaded_q   <= 1'b0;
            y_valid_q  <= 1'b0;
            y_last_q   <= 1'b0;
            y_data_q   <= '0;
            shreg_q    <= '0;
            for (int k = 0; k < N_TAPS; k++) begin
                h_q[k] <= '0;
                x_q[k] <= '0;
            end
        end else if (coef_reload) begin
            // Reload wins over any transfer this cycle; pending beats are dropped.
            state_q    <= ST_LOAD;
            coef_cnt_q <= '0;
            beat_cnt_q <= '0;
            in_ready_q <= 1'b1;
            loaded_q   <= 1'b0;
            y_valid_q  <= 1'b0;
            y_last_q   <= 1'b0;
            y_data_q   <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (w_xfer) begin
                        h_q[coef_cnt_q] <= signed'(in_data);
                        if (coef_cnt_q == CW'(N_TAPS - 1)) begin
                            coef_cnt_q <= '0;
                            loaded_q   <= 1'b1;
                            state_q    <= ST_RUN;
                            for (int k = 0; k < N_TAPS; k++) begin
                                x_q[k] <= '0;
                            end
                        end else begin
                            coef_cnt_q <= coef_cnt_q + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_xfer) begin
                        x_q        <= w_x_next;
                        y_data_q   <= w_word[BW_SR-1 -: BW_OUT];
                        shreg_q    <= w_word << BW_OUT;
                        y_valid_q  <= 1'b1;
                        y_last_q   <= (BEATS == 1);
                        beat_cnt_q <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (beat_cnt_q == BCW'(BEATS - 1)) begin
                        y_valid_q  <= 1'b0;
                        y_last_q   <= 1'b0;
                        y_data_q   <= '0;
                        in_ready_q <= 1'b1;
                        state_q    <= ST_RUN;
                    end else begin
                        y_data_q   <= shreg_q[BW_SR-1 -: BW_OUT];
                        shreg_q    <= shreg_q << BW_OUT;
                        y_last_q   <= (beat_cnt_q == BCW'(BEATS - 2));
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_LOAD;
                    coef_cnt_q <= '0;
                    in_ready_q <= 1'b1;
                    loaded_q   <= 1'b0;
                    y_valid_q  <= 1'b0;
                    y_last_q   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign loaded   = loaded_q;
    assign y_valid  = y_valid_q;
    assign y_last   = y_last_q;
    assign y_data   = y_data_q;

endmodule

`default_nettype wire
